tea_engine: RTL

Memory-mapped hardware TEA block cipher coprocessor on the 5-bit/8-bit `io_*` peripheral bus driven by `tea_cpu`. It replaces the software TEA loop with an iterative datapath that performs one half-round per clock. Round count and delta are parameters, and encrypt or decrypt is selected at run time. Plaintext, key and result are exchanged as bytes through the same register window the CPU already uses for TEA data.

---
 rtl/tea_engine_pkg.sv | 31 +++
 rtl/tea_engine_if.sv | 20 ++
 rtl/tea_feistel_f.sv | 18 +
 rtl/tea_engine.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/tea_engine_pkg.sv
// Shared definitions for the TEA coprocessor:
// register map, control bits, FSM states.
package tea_pkg;

  localparam logic [4:0] TEA_V0   = 5'h00;
  localparam logic [4:0] TEA_V1   = 5'h04;
  localparam logic [4:0] TEA_KEY  = 5'h08;
  localparam logic [4:0] TEA_SUM  = 5'h1C;
  localparam logic [4:0] TEA_CNT  = 5'h1D;
  localparam logic [4:0] TEA_CTRL = 5'h1E;
  localparam logic [4:0] TEA_STAT = 5'h1F;

  localparam int CTRL_START = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_IE    = 3;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_IE   = 3;

  localparam logic [31:0] TEA_DELTA = 32'h9E3779B9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_V0,
    S_V1,
    S_FIN
  } tea_state_e;

endpackage

// File: rtl/tea_engine_if.sv
// Byte-wide io_* peripheral bus as seen by the
// TEA coprocessor, plus its interrupt line.
interface tea_engine_if;
  logic [4:0] io_addr;
  logic       io_rd;
  logic       io_wr;
  logic [7:0] io_wrdata;
  logic [7:0] io_rddata;
  logic       irq;

  modport master (
    output io_addr, io_rd, io_wr, io_wrdata,
    input  io_rddata, irq
  );

  modport slave (
    input  io_addr, io_rd, io_wr, io_wrdata,
    output io_rddata, irq
  );
endinterface

// File: rtl/tea_feistel_f.sv
// TEA mixing function F(x, s, ka, kb), purely
// combinational, mod 2^32 with logical shifts.
module tea_feistel_f (
  input  logic [31:0] x,
  input  logic [31:0] s,
  input  logic [31:0] ka,
  input  logic [31:0] kb,
  output logic [31:0] f
);
  logic [31:0] t_shl;
  logic [31:0] t_sum;
  logic [31:0] t_shr;

  assign t_shl = (x << 4) + ka;
  assign t_sum = x + s;
  assign t_shr = (x >> 5) + kb;
  assign f     = t_shl ^ t_sum ^ t_shr;
endmodule

// File: rtl/tea_engine.sv
// Iterative TEA coprocessor: one half-round per
// clock, byte-mapped on the io_* bus.
module tea_engine
  import tea_pkg::*;
#(
  parameter int unsigned ROUNDS  = 32,
  parameter logic [31:0] DELTA   = TEA_DELTA,
  parameter logic [31:0] SUM_DEC = 32'(DELTA * ROUNDS)
) (
  input logic   clk,
  input logic   rst,
  tea_engine_if.slave bus
);

  localparam logic [7:0] CNT_INIT = 8'(ROUNDS);

  tea_state_e state_q, state_d;
  // words: 0 v0, 1 v1, 2..5 K0..K3
  logic [5:0][31:0] bank_q, bank_d;
  logic [31:0] sum_q, sum_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic        ie_q, ie_d;

  logic [4:0]  addr;
  logic [2:0]  word;
  logic [4:0]  bsel;
  logic        bank_hit;
  logic        ctrl_wr;
  logic        stat_wr;
  logic        start;
  logic        abort;
  logic        busy;
  logic        half_v1;
  logic [31:0] v0;
  logic [31:0] v1;
  logic [31:0] sum_inc;
  logic [31:0] f_x;
  logic [31:0] f_s;
  logic [31:0] f_ka;
  logic [31:0] f_kb;
  logic [31:0] f_out;
  logic [7:0]  rd;
  logic        unused_rd;

  assign addr     = bus.io_addr;
  assign word     = addr[4:2];
  assign bsel     = {addr[1:0], 3'b000};
  assign bank_hit = addr < (TEA_KEY + 5'd16);
  assign ctrl_wr  = bus.io_wr && (addr == TEA_CTRL);
  assign stat_wr  = bus.io_wr && (addr == TEA_STAT);
  assign start    = ctrl_wr && bus.io_wrdata[CTRL_START];
  assign abort    = ctrl_wr && bus.io_wrdata[CTRL_ABORT];
  assign busy     = state_q != S_IDLE;
  assign v0       = bank_q[0];
  assign v1       = bank_q[1];

  // Encrypt V0 already sees the incremented sum.
  assign half_v1 = state_q == S_V1;
  assign sum_inc = sum_q + DELTA;
  assign f_x     = half_v1 ? v0 : v1;
  assign f_ka    = half_v1 ? bank_q[4] : bank_q[2];
  assign f_kb    = half_v1 ? bank_q[5] : bank_q[3];
  assign f_s     = (state_q == S_V0 && !mode_q)
                 ? sum_inc : sum_q;

  tea_feistel_f u_f (
    .x  (f_x),
    .s  (f_s),
    .ka (f_ka),
    .kb (f_kb),
    .f  (f_out)
  );

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = done_q;
    ie_d    = ie_q;

    if (ctrl_wr) ie_d = bus.io_wrdata[CTRL_IE];
    if (stat_wr && bus.io_wrdata[STAT_DONE]) begin
      done_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.io_wr && bank_hit) begin
          bank_d[word][bsel +: 8] = bus.io_wrdata;
        end
        if (start && !abort) begin
          mode_d  = bus.io_wrdata[CTRL_MODE];
          done_d  = 1'b0;
          cnt_d   = CNT_INIT;
          sum_d   = mode_d ? SUM_DEC : 32'h0;
          state_d = mode_d ? S_V1 : S_V0;
        end
      end
      S_V0: begin
        if (!mode_q) begin
          sum_d     = sum_inc;
          bank_d[0] = v0 + f_out;
          state_d   = S_V1;
        end else begin
          bank_d[0] = v0 - f_out;
          sum_d     = sum_q - DELTA;
          cnt_d     = cnt_q - 8'd1;
          state_d   = (cnt_q == 8'd1) ? S_FIN : S_V1;
        end
      end
      S_V1: begin
        if (!mode_q) begin
          bank_d[1] = v1 + f_out;
          cnt_d     = cnt_q - 8'd1;
          state_d   = (cnt_q == 8'd1) ? S_FIN : S_V0;
        end else begin
          bank_d[1] = v1 - f_out;
          state_d   = S_V0;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    if (busy && abort) begin
      done_d  = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      ie_q    <= ie_d;
    end
  end

  always_comb begin
    rd = 8'h00;
    unique case (1'b1)
      bank_hit:           rd = bank_q[word][bsel +: 8];
      (addr == TEA_SUM):  rd = sum_q[7:0];
      (addr == TEA_CNT):  rd = cnt_q;
      (addr == TEA_STAT): begin
        rd[STAT_BUSY] = busy;
        rd[STAT_DONE] = done_q;
        rd[STAT_IE]   = ie_q;
      end
      default:            rd = 8'h00;
    endcase
  end

  assign bus.io_rddata = rd;
  assign bus.irq       = done_q & ie_q;
  // Reads are side-effect free, so the strobe is unused.
  assign unused_rd     = bus.io_rd;

endmodule
